pipeline_hazard_sequencer: RTL and testbench
============================================

PIPELINE_HAZARD_SEQUENCER -- requirements
Module: pipeline_hazard_sequencer

Interface
REQ-001 SHALL have one clock domain; reset is synchronous and active-high.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port memReadE, input, 1 bit: instruction in EX is a load.
REQ-005 SHALL have port write_regE, input, 5 bits: destination register of the EX instruction.
REQ-006 SHALL have ports read_reg1D and read_reg2D, input, 5 bits each: source registers of the ID instruction.
REQ-007 SHALL have ports useRs1D and useRs2D, input, 1 bit each: the ID instruction actually reads that source.
REQ-008 SHALL have port branch_takenE, input, 1 bit: branch/jump resolved taken in EX.
REQ-009 SHALL have port dmem_reqM, input, 1 bit: MEM-stage instruction accesses data memory.
REQ-010 SHALL have port dmem_ready, input, 1 bit: data memory completes the access this cycle.
REQ-011 SHALL have ports stallF, stallD, stallE and stallM, output, 1 bit each: hold the PC, IF/ID, ID/EX and EX/MEM registers respectively.
REQ-012 SHALL have ports flushD and flushE, output, 1 bit each: clear IF/ID or ID/EX to a bubble.
REQ-013 SHALL have port mem_timeout, output, 1 bit: sticky error flag for a memory wait longer than 255 cycles.
REQ-014 SHALL have ports stall_cycles and flush_events, output, 16 bits each: saturating performance counters.

Function
REQ-015 SHALL implement FSM states INIT, RUN and MEM_WAIT; stall and flush outputs are combinational from the state and current inputs.
REQ-016 INIT: flushD=flushE=1 and all stalls=0.
- INIT lasts exactly 2 cycles after reset deasserts, counted by a 1-bit init counter, then goes to RUN.
REQ-017 Freeze condition: (state RUN or MEM_WAIT) and dmem_reqM=1 and dmem_ready=0.
- Drives stallF=stallD=stallE=stallM=1 and flushD=flushE=0.
- Overrides every other condition.
REQ-018 RUN with the freeze condition true SHALL go to MEM_WAIT next cycle.
- MEM_WAIT with dmem_ready=1 SHALL drive no freeze that cycle and return to RUN next cycle.
REQ-019 MEM_WAIT SHALL increment an 8-bit wait counter each frozen cycle.
- The counter clears on entry to RUN.
- When it reaches 255, mem_timeout SHALL be set and stay set until reset; the freeze continues.
REQ-020 Branch flush: not frozen and branch_takenE=1 drives flushD=flushE=1 and stallF=stallD=0.
- Branch flush has priority over load-use.
REQ-021 Load-use hazard: not frozen, no branch, memReadE=1, write_regE!=0, and (useRs1D and read_reg1D==write_regE, or useRs2D and read_reg2D==write_regE).
- Drives stallF=stallD=1 and flushE=1 for that cycle only.
REQ-022 A source that matches write_regE with its use flag at 0, or write_regE==0, SHALL NOT cause a stall.
REQ-023 stall_cycles SHALL increment on each cycle stallF=1 and saturate at 16'hFFFF.
REQ-024 flush_events SHALL increment on each cycle the branch flush is taken and saturate at 16'hFFFF.
- INIT flushes are not counted.
REQ-025 With no hazard, stall, flush or INIT condition, all stall and flush outputs SHALL be 0.

Reset
REQ-026 reset=1 SHALL force state INIT, the init counter and wait counter to 0, mem_timeout=0, and stall_cycles=flush_events=0.
REQ-027 While reset=1, outputs SHALL be flushD=flushE=1 and all stalls=0.
REQ-028 Reset asserted mid-MEM_WAIT SHALL abandon the wait; the next cycle SHALL be INIT regardless of dmem_ready.

Verification
REQ-029 Release reset, all inputs 0 -> flushD=flushE=1 for 2 cycles, then all outputs 0 and counters 0.
REQ-030 memReadE=1, write_regE=5, read_reg2D=5, useRs2D=1 for 1 cycle -> stallF=stallD=flushE=1 that cycle, stall_cycles=1; same case with write_regE=0 -> no stall.
REQ-031 Load-use condition and branch_takenE=1 together -> flushD=flushE=1, stallF=0, flush_events=1, stall_cycles unchanged.
REQ-032 dmem_reqM=1, dmem_ready=0 for 3 cycles, then ready=1 -> all four stalls=1 for 3 cycles, then 0; state returns to RUN; stall_cycles=3.
REQ-033 dmem_reqM=1, dmem_ready=0 held for 300 cycles -> mem_timeout rises after 255 MEM_WAIT cycles and stays 1 after ready; reset clears it.
REQ-034 Force 70000 load-use stall cycles -> stall_cycles holds at 16'hFFFF with no wrap.

Source files
------------

// File: rtl/pipeline_hazard_sequencer.sv
// Hazard control for a five-stage pipeline. It sequences the reset bubbles,
// load-use stalls, branch flushes and data-memory freezes, and keeps stall/flush statistics.
module pipeline_hazard_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        memReadE,
  input  logic [4:0]  write_regE,
  input  logic [4:0]  read_reg1D,
  input  logic [4:0]  read_reg2D,
  input  logic        useRs1D,
  input  logic        useRs2D,
  input  logic        branch_takenE,
  input  logic        dmem_reqM,
  input  logic        dmem_ready,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        stallM,
  output logic        flushD,
  output logic        flushE,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events,
  output logic [1:0]  state
);

  localparam logic [1:0] INIT     = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       init_cnt;
  logic [7:0] wait_cnt;
  logic       active;
  logic       frozen;
  logic       branch_flush;
  logic       load_use;
  logic       src1_hit;
  logic       src2_hit;

  assign state = state_q;

  // Handshake: the MEM-stage access completes in the cycle where dmem_reqM and
  // dmem_ready are both 1; a request with dmem_ready=0 holds the whole pipe.
  assign active       = !reset && ((state_q == RUN) || (state_q == MEM_WAIT));
  assign frozen       = active && dmem_reqM && !dmem_ready;
  assign branch_flush = active && !frozen && branch_takenE;

  assign src1_hit = useRs1D && (read_reg1D == write_regE);
  assign src2_hit = useRs2D && (read_reg2D == write_regE);
  assign load_use = active && !frozen && !branch_takenE && memReadE &&
                    (write_regE != 5'd0) && (src1_hit || src2_hit);

  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    if (!active) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (frozen) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
    end else if (branch_flush) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (load_use) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:     if (init_cnt) state_d = RUN;
      RUN:      if (frozen) state_d = MEM_WAIT;
      MEM_WAIT: if (!frozen) state_d = RUN;
      default:  state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= INIT;
      init_cnt     <= 1'b0;
      wait_cnt     <= 8'd0;
      mem_timeout  <= 1'b0;
      stall_cycles <= 16'd0;
      flush_events <= 16'd0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) init_cnt <= 1'b1;

      // The wait counter parks at 255 so the timeout flag is set exactly once.
      if ((state_d == RUN) && (state_q != RUN)) begin
        wait_cnt <= 8'd0;
      end else if ((state_q == MEM_WAIT) && frozen && (wait_cnt != 8'hFF)) begin
        wait_cnt <= wait_cnt + 8'd1;
        if (wait_cnt == 8'hFE) mem_timeout <= 1'b1;
      end

      if (stallF && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
      if (branch_flush && (flush_events != 16'hFFFF)) flush_events <= flush_events + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed bench for pipeline_hazard_sequencer: expected control vectors are
// queued per cycle and checked at the falling edge; counters follow a small model.
module tb_pipeline_hazard_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        memReadE;
  logic [4:0]  write_regE;
  logic [4:0]  read_reg1D;
  logic [4:0]  read_reg2D;
  logic        useRs1D;
  logic        useRs2D;
  logic        branch_takenE;
  logic        dmem_reqM;
  logic        dmem_ready;
  logic        stallF;
  logic        stallD;
  logic        stallE;
  logic        stallM;
  logic        flushD;
  logic        flushE;
  logic        mem_timeout;
  logic [15:0] stall_cycles;
  logic [15:0] flush_events;
  logic [1:0]  state;

  // Vector order: {stallF, stallD, stallE, stallM, flushD, flushE}
  localparam logic [5:0] V_IDLE = 6'b000000;
  localparam logic [5:0] V_INIT = 6'b000011;
  localparam logic [5:0] V_LU   = 6'b110001;
  localparam logic [5:0] V_FRZ  = 6'b111100;
  localparam logic [5:0] V_BR   = 6'b000011;

  localparam logic [1:0] S_INIT     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_MEM_WAIT = 2'd2;

  logic [5:0]  exp_q[$];
  string       tag_q[$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  int unsigned m_stall      = 0;
  int unsigned m_flush      = 0;

  pipeline_hazard_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .memReadE     (memReadE),
    .write_regE   (write_regE),
    .read_reg1D   (read_reg1D),
    .read_reg2D   (read_reg2D),
    .useRs1D      (useRs1D),
    .useRs2D      (useRs2D),
    .branch_takenE(branch_takenE),
    .dmem_reqM    (dmem_reqM),
    .dmem_ready   (dmem_ready),
    .stallF       (stallF),
    .stallD       (stallD),
    .stallE       (stallE),
    .stallM       (stallM),
    .flushD       (flushD),
    .flushE       (flushE),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic mr, input logic [4:0] wr, input logic [4:0] r1,
                       input logic [4:0] r2, input logic u1, input logic u2,
                       input logic br, input logic req, input logic rdy);
    memReadE      = mr;
    write_regE    = wr;
    read_reg1D    = r1;
    read_reg2D    = r2;
    useRs1D       = u1;
    useRs2D       = u2;
    branch_takenE = br;
    dmem_reqM     = req;
    dmem_ready    = rdy;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: queue the expected vector, compare at the falling edge, then let the edge happen.
  task automatic step(input logic [5:0] e, input logic br_cnt, input string tag);
    logic [5:0] got;
    logic [5:0] want;
    string      t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    got  = {stallF, stallD, stallE, stallM, flushD, flushE};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    check(t, {26'd0, got}, {26'd0, want});
    if (reset) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (want[5] && (m_stall != 65535)) m_stall++;
      if (br_cnt && (m_flush != 65535)) m_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_stall_cycles"}, {16'd0, stall_cycles}, m_stall);
    check({tag, "_flush_events"}, {16'd0, flush_events}, m_flush);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    #1;
    step(V_INIT, 0, "reset_hold_0");
    step(V_INIT, 0, "reset_hold_1");
    check("reset_state", {30'd0, state}, {30'd0, S_INIT});
    check("reset_timeout", {31'd0, mem_timeout}, 32'd0);
    check_counters("reset");

    // Exactly two INIT cycles after release
    reset = 1'b0;
    step(V_INIT, 0, "init_cycle_1");
    check("init_still_init", {30'd0, state}, {30'd0, S_INIT});
    step(V_INIT, 0, "init_cycle_2");
    check("init_to_run", {30'd0, state}, {30'd0, S_RUN});
    step(V_IDLE, 0, "idle_after_init");
    check_counters("idle");

    // Load-use on rs2
    drive(1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 0, 0);
    step(V_LU, 0, "load_use_rs2");
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    step(V_IDLE, 0, "load_use_released");
    check_counters("load_use");

    // Load-use on rs1 with unrelated rs2
    drive(1, 5'd9, 5'd9, 5'd3, 1, 1, 0, 0, 0);
    step(V_LU, 0, "load_use_rs1");

    // Register 0 and unused sources never stall
    drive(1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0);
    step(V_IDLE, 0, "no_stall_x0");
    drive(1, 5'd5, 5'd5, 5'd5, 0, 0, 0, 0, 0);
    step(V_IDLE, 0, "no_stall_unused_src");
    drive(0, 5'd5, 5'd5, 5'd5, 1, 1, 0, 0, 0);
    step(V_IDLE, 0, "no_stall_not_load");
    check_counters("no_stall");

    // Branch beats load-use
    drive(1, 5'd5, 5'd0, 5'd5, 0, 1, 1, 0, 0);
    step(V_BR, 1, "branch_over_load_use");
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    step(V_IDLE, 0, "branch_released");
    check_counters("branch");

    // Three-cycle memory freeze
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    step(V_FRZ, 0, "freeze_1");
    check("freeze_enters_wait", {30'd0, state}, {30'd0, S_MEM_WAIT});
    step(V_FRZ, 0, "freeze_2");
    step(V_FRZ, 0, "freeze_3");
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1);
    step(V_IDLE, 0, "freeze_ready");
    check("freeze_back_to_run", {30'd0, state}, {30'd0, S_RUN});
    check_counters("freeze");

    // Freeze overrides branch and load-use; branch then acts on the ready cycle
    drive(1, 5'd7, 5'd7, 5'd0, 1, 0, 1, 1, 0);
    step(V_FRZ, 0, "freeze_over_branch");
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 1);
    step(V_BR, 1, "branch_on_ready");
    check("branch_ready_run", {30'd0, state}, {30'd0, S_RUN});
    check_counters("freeze_branch");

    // Timeout after 255 MEM_WAIT cycles (the first frozen cycle is still RUN)
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 255; i++) step(V_FRZ, 0, "timeout_wait");
    check("timeout_not_yet", {31'd0, mem_timeout}, 32'd0);
    step(V_FRZ, 0, "timeout_edge");
    check("timeout_set", {31'd0, mem_timeout}, 32'd1);
    for (int i = 0; i < 44; i++) step(V_FRZ, 0, "timeout_hold");
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1);
    step(V_IDLE, 0, "timeout_ready");
    check("timeout_sticky", {31'd0, mem_timeout}, 32'd1);
    check_counters("timeout");
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step(V_INIT, 0, "timeout_reset");
    check("timeout_cleared", {31'd0, mem_timeout}, 32'd0);
    check_counters("after_reset");

    // Reset abandons a memory wait
    reset = 1'b0;
    step(V_INIT, 0, "reinit_1");
    step(V_INIT, 0, "reinit_2");
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    step(V_FRZ, 0, "abort_freeze_1");
    step(V_FRZ, 0, "abort_freeze_2");
    reset = 1'b1;
    step(V_INIT, 0, "abort_reset");
    reset = 1'b0;
    check("abort_state_init", {30'd0, state}, {30'd0, S_INIT});
    step(V_INIT, 0, "abort_init_1");
    step(V_INIT, 0, "abort_init_2");
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    step(V_IDLE, 0, "abort_idle");
    check_counters("abort");

    // Stall counter saturation
    drive(1, 5'd12, 5'd12, 5'd0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) step(V_LU, 0, "sat_load_use");
    check("sat_stall_ffff", {16'd0, stall_cycles}, 32'h0000FFFF);
    check_counters("sat");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
